// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (round-robin contention policy).
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

endpackage

// File: rtl/arb2_select.sv
// Two-requester grant decision.
// Macro RAM_ARB_ROUND_ROBIN_EN: when defined, a pointer input picks the
// favoured requester on contention; otherwise requester 0 always wins and
// the pointer port does not exist.
module arb2_select
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  logic ptr,
`endif
    output logic sel0,
    output logic sel1
);

    // Resolve at most one selected requester
    always_comb begin
        sel0 = 1'b0;
        sel1 = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            sel0 = ~ptr;
            sel1 = ptr;
        end else begin
            sel0 = req0;
            sel1 = req1;
        end
`else
        sel0 = req0;
        sel1 = req1 & ~req0;
`endif
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto a single simple-dual-port RAM.
// One transaction per two cycles: IDLE decides, SERVEn performs the access.
// Macro RAM_ARB_ROUND_ROBIN_EN: round-robin contention policy with a
// one-bit pointer; undefined gives fixed priority to requester 0.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [ADDR_W-1:0] ram_rdaddress,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            state_q;
    state_t            state_d;
    logic              sel0;
    logic              sel1;
    logic              rd0;
    logic              rd1;
    logic              rv0_q;
    logic              rv1_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic rr_q;
`endif

    arb2_select u_sel (
        .req0 (req0),
        .req1 (req1),
`ifdef RAM_ARB_ROUND_ROBIN_EN
        .ptr  (rr_q),
`endif
        .sel0 (sel0),
        .sel1 (sel1)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state: IDLE arbitrates, any SERVE returns to IDLE
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (sel0)      state_d = SERVE0;
                else if (sel1) state_d = SERVE1;
                else           state_d = IDLE;
            end
            SERVE0:  state_d = IDLE;
            SERVE1:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants and RAM port drive, combinational from the served requester
    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        rd0           = 1'b0;
        rd1           = 1'b0;
        ram_wren      = 1'b0;
        ram_data      = '0;
        ram_wraddress = '0;
        ram_rdaddress = '0;
        case (state_q)
            SERVE0: begin
                gnt0 = 1'b1;
                if (we0) begin
                    ram_wren      = 1'b1;
                    ram_wraddress = addr0;
                    ram_data      = wdata0;
                end else begin
                    rd0           = 1'b1;
                    ram_rdaddress = addr0;
                end
            end
            SERVE1: begin
                gnt1 = 1'b1;
                if (we1) begin
                    ram_wren      = 1'b1;
                    ram_wraddress = addr1;
                    ram_data      = wdata1;
                end else begin
                    rd1           = 1'b1;
                    ram_rdaddress = addr1;
                end
            end
            default: ;
        endcase
    end

    // Read capture and rvalid pulse one cycle after the read access
    always_ff @(posedge clock) begin
        if (reset) begin
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            rv0_q <= rd0;
            rv1_q <= rd1;
            if (rd0 || rd1) rdata_q <= ram_q;
        end
    end

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Pointer favours the requester that was not just served
    always_ff @(posedge clock) begin
        if (reset)                 rr_q <= 1'b0;
        else if (state_q == SERVE0) rr_q <= 1'b1;
        else if (state_q == SERVE1) rr_q <= 1'b0;
    end
`endif

    assign rvalid0 = rv0_q;
    assign rvalid1 = rv1_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus pushes expected grant and
// rvalid events; a negedge monitor pops and compares each observed pulse.
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_wren;
    logic [DW-1:0] rdata, ram_data, ram_q;
    logic [AW-1:0] ram_wraddress, ram_rdaddress;

    typedef struct {
        int            kind;   // 0 gnt0, 1 gnt1, 2 rvalid0, 3 rvalid1
        int            cyc;
        logic          wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_data(ram_data),
        .ram_wraddress(ram_wraddress), .ram_rdaddress(ram_rdaddress),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: registered write, combinational read
    always @(posedge clock) if (ram_wren) mem[ram_wraddress] <= ram_data;
    always_comb ram_q = mem[ram_rdaddress];

    function automatic string kname(input int k);
        case (k)
            0: return "gnt0";
            1: return "gnt1";
            2: return "rvalid0";
            default: return "rvalid1";
        endcase
    endfunction

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clock) begin
        int   n;
        int   k;
        logic ok;
        exp_t e;
        n = int'(gnt0) + int'(gnt1) + int'(rvalid0) + int'(rvalid1);
        if (n != 0) begin
            k = gnt0 ? 0 : gnt1 ? 1 : rvalid0 ? 2 : 3;
            tests++;
            if (n > 1) begin
                fails++;
                $display("FAIL multi_pulse cyc=%0d got g0=%b g1=%b rv0=%b rv1=%b required single pulse",
                         cyc, gnt0, gnt1, rvalid0, rvalid1);
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_%s cyc=%0d got pulse required none", kname(k), cyc);
            end else begin
                e = sb.pop_front();
                if (k < 2)
                    ok = (k == e.kind) && (cyc == e.cyc) && (ram_wren == e.wren) &&
                         (e.wren ? (ram_wraddress == e.addr && ram_data == e.data)
                                 : (ram_rdaddress == e.addr));
                else
                    ok = (k == e.kind) && (cyc == e.cyc) && (rdata == e.data);
                if (!ok) begin
                    fails++;
                    $display("FAIL event_%s cyc=%0d got kind=%s wren=%b wa=%h ra=%h wd=%h rd=%h required kind=%s cyc=%0d wren=%b addr=%h data=%h",
                             kname(e.kind), cyc, kname(k), ram_wren, ram_wraddress, ram_rdaddress,
                             ram_data, rdata, kname(e.kind), e.cyc, e.wren, e.addr, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask

    task automatic push(input int kind, input int c, input logic wren,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.kind = kind; e.cyc = c; e.wren = wren; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    // One transaction from a single requester; call from an IDLE cycle
    task automatic op(input int who, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [DW-1:0] rexp);
        push(who, cyc + 1, we, a, we ? d : '0);
        if (!we) push(who + 2, cyc + 2, 1'b0, '0, rexp);
        if (who == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        else          begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        step();
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    initial begin
        int c;
        repeat (3) step();
        chk("reset_gnt0", 32'(gnt0), 32'd0);
        chk("reset_gnt1", 32'(gnt1), 32'd0);
        chk("reset_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_wren", 32'(ram_wren), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_wraddr", 32'(ram_wraddress), 32'd0);

        op(0, 1'b1, 12'h005, 16'hBEEF, '0);
        op(1, 1'b0, 12'h005, '0, 16'hBEEF);
        op(0, 1'b1, 12'h000, 16'h1234, '0);
        op(1, 1'b1, 12'hFFF, 16'hA5C3, '0);
        op(0, 1'b0, 12'hFFF, '0, 16'hA5C3);
        op(1, 1'b0, 12'h000, '0, 16'h1234);
        op(0, 1'b1, 12'h100, 16'h0F0F, '0);
        chk("rdata_hold_after_write", 32'(rdata), 32'h1234);

        // Contention from a fresh reset, both held for four grants
        reset = 1'b1;
        step();
        reset = 1'b0;
        c = cyc;
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h010; wdata0 = 16'h1111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h020; wdata1 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            if (i % 2 == 0) push(0, c + 1 + 2*i, 1'b1, 12'h010, 16'h1111);
            else            push(1, c + 1 + 2*i, 1'b1, 12'h020, 16'h2222);
`else
            push(0, c + 1 + 2*i, 1'b1, 12'h010, 16'h1111);
`endif
        end
        repeat (7) step();
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        // Abort a read with reset during its SERVE0 cycle
        op(1, 1'b0, 12'h010, '0, 16'h1111);
        chk("rdata_before_abort", 32'(rdata), 32'h1111);
        push(0, cyc + 1, 1'b0, 12'hFFF, '0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'hFFF;
        step();
        req0 = 1'b0;
        reset = 1'b1;
        step();
        chk("abort_rvalid0", 32'(rvalid0), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        chk("abort_gnt", 32'({gnt0, gnt1}), 32'd0);
        reset = 1'b0;
        step();
        chk("abort_idle_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("abort_idle_wren", 32'(ram_wren), 32'd0);
        op(0, 1'b0, 12'h000, '0, 16'h1234);

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_%s got none required cyc=%0d", kname(e.kind), e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, RAM address width.
REQ-002 Parameter DATA_W, default 16, RAM data width.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1  requester n transaction request; held high until that requester's gnt.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; stable while req high.
REQ-007 addr0 / addr1  input  ADDR_W  transaction address; stable while req high.
REQ-008 wdata0 / wdata1  input  DATA_W  write data; stable while req high.
REQ-009 gnt0 / gnt1  output  1  one-cycle pulse; transaction accepted this cycle.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse; rdata holds read result.
REQ-011 rdata  output  DATA_W  registered read data, shared by both requesters.
REQ-012 ram_data  output  DATA_W  to RAM data.
REQ-013 ram_wraddress / ram_rdaddress  output  ADDR_W  to RAM write/read address.
REQ-014 ram_wren  output  1  to RAM wren.
REQ-015 ram_q  input  DATA_W  RAM read data, combinational from ram_rdaddress.

Function
REQ-016 FSM states SHALL be IDLE, SERVE0, SERVE1.
REQ-017 IDLE with no req SHALL stay IDLE; with exactly one req SHALL go to that requester's SERVEn next cycle.
REQ-018 IDLE with both req SHALL resolve per REQ-031/REQ-032.
REQ-019 SERVEn SHALL always go to IDLE next cycle; req sampled in SERVEn is ignored, so peak throughput is one transaction per two cycles.
REQ-020 In SERVEn, gnt_n SHALL be 1 and the other gnt 0; gnt SHALL be 0 in IDLE.
REQ-021 In SERVEn with we_n=1, ram_wren=1, ram_wraddress=addr_n, ram_data=wdata_n, all combinational from requester n.
REQ-022 In SERVEn with we_n=0, ram_wren=0, ram_rdaddress=addr_n; rdata SHALL register ram_q at end of that cycle and rvalid_n SHALL pulse the following cycle.
REQ-023 In IDLE, ram_wren SHALL be 0 and ram addresses/data 0.
REQ-024 rdata SHALL hold its value until the next read completes; writes do not alter it.
REQ-025 Only one RAM access per cycle; write/read same-address collisions SHALL be impossible by construction.
REQ-026 Read latency: req seen in IDLE at cycle N -> gnt at N+1 -> rvalid at N+2.
REQ-027 Address arithmetic none; addresses pass through unmodified, full 0..2^ADDR_W-1 range.

Reset
REQ-028 reset SHALL force IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata=0, rr pointer=0 on the next edge.
REQ-029 Reset asserted during SERVEn SHALL abort: a write in that cycle is still presented to RAM combinationally, a pending rvalid SHALL be suppressed.
REQ-030 Requests held through reset SHALL be arbitrated normally from the first post-reset IDLE.

Configuration
REQ-031 With RAM_ARB_ROUND_ROBIN_EN defined: 1-bit pointer names the favoured requester on contention; after SERVEn the pointer SHALL become the other requester.
REQ-032 Without RAM_ARB_ROUND_ROBIN_EN: fixed priority, requester 0 wins every contention; no pointer register.

Structure
REQ-033 Package ram_arb_pkg SHALL hold the FSM state typedef and ADDR_W/DATA_W defaults.
REQ-034 Sub-module arb2_select (2-input grant decision, pointer input, macro-dependent) SHALL be instantiated once.

Verification
REQ-035 Reset, then req0 write addr 0x005 data 0xBEEF -> gnt0 next cycle, ram_wren=1, ram_wraddress=0x005, ram_data=0xBEEF.
REQ-036 req1 read addr 0x005 with ram model returning 0xBEEF -> gnt1 at N+1, rvalid1 at N+2, rdata=0xBEEF.
REQ-037 req0 and req1 held high continuously, round-robin -> grants alternate 0,1,0,1 every two cycles; without macro -> only gnt0.
REQ-038 Addresses 0x000 and 0xFFF write/read -> correct pass-through, no wrap or truncation.
REQ-039 Reset asserted in the SERVE0 read cycle -> no rvalid0, rdata=0, state IDLE.
